regfile_2r1w: RTL and testbench



---
 rtl/regfile_2r1w.sv | 128 ++++++++++++
 tb/tb_regfile_2r1w.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with clear sequencer.
// Define REGFILE_FWD_EN for write-first forwarding; default is read-first.
module regfile_2r1w #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              ready,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH-1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_a;
   logic [DATA_W-1:0] r_rd_b;

   logic              w_ready;
   logic              w_clearing;
   logic              w_wr_ok;
   logic              w_a_ok;
   logic              w_b_ok;
   logic              w_fwd_a;
   logic              w_fwd_b;
   logic [CNT_W-1:0]  w_wr_idx;
   logic [CNT_W-1:0]  w_a_idx;
   logic [CNT_W-1:0]  w_b_idx;
   logic [DATA_W-1:0] w_a_val;
   logic [DATA_W-1:0] w_b_val;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // State register; reset always restarts the clear from entry 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_CLEAR;
      else        r_state <= w_next;
   end

   // Next state: leave CLEAR after the last entry, re-enter on clr_req
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_CLEAR: if (r_cnt == LAST) w_next = S_READY;
         S_READY: if (clr_req)       w_next = S_CLEAR;
      endcase
   end

   // State decode outputs
   always_comb begin
      w_ready    = (r_state == S_READY);
      w_clearing = (r_state == S_CLEAR);
   end

   // Clear counter walks every entry once per clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_cnt <= '0;
      else if (w_clearing) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      else if (clr_req)    r_cnt <= '0;
   end

   // Address qualification, index truncation and optional forwarding
   always_comb begin
      w_wr_ok  = w_ready && wr_en && addr_ok(wr_addr);
      w_a_ok   = addr_ok(rd_addr_a);
      w_b_ok   = addr_ok(rd_addr_b);
      w_wr_idx = wr_addr[CNT_W-1:0];
      w_a_idx  = rd_addr_a[CNT_W-1:0];
      w_b_idx  = rd_addr_b[CNT_W-1:0];
`ifdef REGFILE_FWD_EN
      w_fwd_a  = w_wr_ok && (rd_addr_a == wr_addr);
      w_fwd_b  = w_wr_ok && (rd_addr_b == wr_addr);
`else
      w_fwd_a  = 1'b0;
      w_fwd_b  = 1'b0;
`endif
      w_a_val  = !w_a_ok ? '0 : (w_fwd_a ? wr_data : r_mem[w_a_idx]);
      w_b_val  = !w_b_ok ? '0 : (w_fwd_b ? wr_data : r_mem[w_b_idx]);
   end

   // Storage: sequencer zeroes entries, otherwise the write port
   always_ff @(posedge clk) begin
      if (w_clearing)   r_mem[r_cnt]    <= '0;
      else if (w_wr_ok) r_mem[w_wr_idx] <= wr_data;
   end

   // Port A read register, forced to zero while clearing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_rd_a <= '0;
      else if (w_clearing) r_rd_a <= '0;
      else if (rd_en_a)    r_rd_a <= w_a_val;
   end

   // Port B read register, forced to zero while clearing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_rd_b <= '0;
      else if (w_clearing) r_rd_b <= '0;
      else if (rd_en_b)    r_rd_b <= w_b_val;
   end

   assign ready     = w_ready;
   assign rd_data_a = r_rd_a;
   assign rd_data_b = r_rd_b;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: scoreboard bench with a behavioural register-file model.
// Follows REGFILE_FWD_EN to select write-first or read-first expectations.
module tb_regfile_2r1w;

   localparam int DW    = 16;
   localparam int AW    = 6;
   localparam int DEPTH = 32;
   localparam int ZR    = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr_req = 1'b0;
   logic          ready;
   logic          rd_en_a = 1'b0;
   logic [AW-1:0] rd_addr_a = '0;
   logic [DW-1:0] rd_data_a;
   logic          rd_en_b = 1'b0;
   logic [AW-1:0] rd_addr_b = '0;
   logic [DW-1:0] rd_data_b;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;

   regfile_2r1w #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(ZR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rdy;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: plain array plus a countdown for the clear
   logic [DW-1:0] mem [DEPTH];
   bit            m_rdy = 1'b0;
   int            m_left = DEPTH;
   logic [DW-1:0] m_a = '0;
   logic [DW-1:0] m_b = '0;

   task automatic chk(input string nm, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, req);
      end
   endtask

   function automatic logic [DW-1:0] mread(input int ad, input bit wv,
                                           input int wa, input int wd);
      if (ad >= DEPTH || (ZR != 0 && ad == 0)) return '0;
`ifdef REGFILE_FWD_EN
      if (wv && wa == ad) return wd[DW-1:0];
`endif
      return mem[ad];
   endfunction

   task automatic step();
      bit wv;
      int wa;
      wa = int'(wr_addr);
      if (!rst_n) begin
         m_rdy = 0; m_left = DEPTH; m_a = '0; m_b = '0;
      end else if (!m_rdy) begin
         m_a = '0; m_b = '0;
         m_left--;
         if (m_left == 0) begin
            m_rdy = 1;
            foreach (mem[i]) mem[i] = '0;
         end
      end else begin
         wv = wr_en && wa < DEPTH && !(ZR != 0 && wa == 0);
         if (rd_en_a) m_a = mread(int'(rd_addr_a), wv, wa, int'(wr_data));
         if (rd_en_b) m_b = mread(int'(rd_addr_b), wv, wa, int'(wr_data));
         if (wv) mem[wa] = wr_data;
         if (clr_req) begin m_rdy = 0; m_left = DEPTH; end
      end
      q.push_back('{m_rdy, m_a, m_b});
   endtask

   // Drive one cycle of inputs at the falling edge and log the expectation
   task automatic cyc(input bit rst, input bit ra_en, input int ra,
                      input bit rb_en, input int rb, input bit we,
                      input int wa, input int wd, input bit clr);
      bit fall;
      @(negedge clk);
      fall      = rst_n && !rst;
      rst_n     = rst;
      rd_en_a   = ra_en;
      rd_addr_a = ra[AW-1:0];
      rd_en_b   = rb_en;
      rd_addr_b = rb[AW-1:0];
      wr_en     = we;
      wr_addr   = wa[AW-1:0];
      wr_data   = wd[DW-1:0];
      clr_req   = clr;
      if (fall) begin
         #1;
         chk("async_rst_ready", int'(ready), 0);
         chk("async_rst_a", int'(rd_data_a), 0);
         chk("async_rst_b", int'(rd_data_b), 0);
      end
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int a, input int d);
      cyc(1, 0, 0, 0, 0, 1, a, d, 0);
   endtask

   // Monitor: compare DUT outputs against the queue after every edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready", int'(ready), int'(e.rdy));
            chk("rd_data_a", int'(rd_data_a), int'(e.a));
            chk("rd_data_b", int'(rd_data_b), int'(e.b));
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(DEPTH + 2);
      for (int i = 0; i < 64; i++) cyc(1, 1, i, 1, 63 - i, 0, 0, 0, 0);

      wr(5, 16'hBEEF);
      cyc(1, 1, 5, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 5, 0, 0, 0, 0);
      idle(1);

      wr(0, 16'h1234);
      cyc(1, 1, 0, 1, 0, 0, 0, 0, 0);
      wr(40, 16'h5555);
      cyc(1, 1, 40, 1, 8, 0, 0, 0, 0);

      wr(7, 16'h1111);
      cyc(1, 1, 7, 1, 7, 1, 7, 16'hA5A5, 0);
      cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);

      for (int i = 1; i < DEPTH; i++) wr(i, i);
      cyc(1, 1, 3, 1, 31, 0, 0, 0, 0);
      cyc(1, 1, 9, 1, 9, 1, 9, 16'h7777, 1);
      cyc(1, 1, 9, 1, 4, 1, 4, 16'hDEAD, 0);
      idle(DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 1, i, 0, 0, 0, 0);

      for (int i = 1; i < DEPTH; i++) wr(i, 16'h100 + i);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(10);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(DEPTH + 2);
      for (int i = 0; i < DEPTH; i += 3) cyc(1, 1, i, 1, i + 1, 0, 0, 0, 0);

      wr(12, 16'h4242);
      cyc(1, 1, 12, 1, 12, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(DEPTH + 2);

      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom % 500) != 0,
             1'($urandom % 2), int'($urandom % 64),
             1'($urandom % 2), int'($urandom % 64),
             ($urandom % 3) != 0, int'($urandom % 48),
             int'($urandom % 65536),
             ($urandom % 150) == 0);
      end

      idle(2);
      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
